pha_extract: RTL and testbench

Pulse-height extractor between the AD9214 sample stream and the histogram SRAM increment sequencer. Keeps a 40-sample window and compares an 8-sample sum of recent samples against an 8-sample baseline sum taken 32 samples earlier. Triggers on a lower-level-discriminator crossing, tracks the pulse peak and emits one scaled pulse height per accepted pulse over a valid/ready handshake. The consumer uses PH directly as the histogram bin address.

---
 rtl/pha_pkg.sv | 19 +
 rtl/pha_window.sv | 47 ++++
 rtl/pha_extract.sv | 143 ++++++++++++++
 tb/tb_pha_extract.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pha_pkg.sv
// rtl/pha_pkg.sv - shared types and constants for the pulse-height extractor
package pha_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        EMIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int SUM_W   = 13;
    localparam int WIN_LEN = 40;
    localparam int CNT_W   = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pha_window.sv
// rtl/pha_window.sv - 40-tap sample window with fill counter and SN/SB sums
module pha_window
    import pha_pkg::*;
#(
    parameter int DW       = 10,
    parameter int BASE_DLY = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             smp_vld,
    input  logic [DW-1:0]    smp,
    output logic             fill_done,
    output logic [DW-1:0]    w0,
    output logic [SUM_W-1:0] sn,
    output logic [SUM_W-1:0] sb
);

    localparam int FILL_W = $clog2(WIN_LEN + 1);

    logic [DW-1:0]     taps [WIN_LEN];
    logic [FILL_W-1:0] fill;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < WIN_LEN; i++) taps[i] <= '0;
            fill <= '0;
        end else if (smp_vld) begin
            taps[0] <= smp;
            for (int i = 1; i < WIN_LEN; i++) taps[i] <= taps[i-1];
            if (fill != FILL_W'(WIN_LEN)) fill <= fill + 1'b1;
        end
    end

    // Sums are taken from the pre-shift taps so FSM decisions see the settled window.
    always_comb begin
        sn = '0;
        sb = '0;
        for (int i = 0; i < 8; i++) begin
            sn = sn + SUM_W'(taps[i]);
            sb = sb + SUM_W'(taps[BASE_DLY+i]);
        end
    end

    assign w0        = taps[0];
    assign fill_done = (fill == FILL_W'(WIN_LEN));

endmodule

// File: rtl/pha_extract.sv
// rtl/pha_extract.sv - trigger/peak FSM, output slot and counters; optional PHA_PILEUP_REJECT_EN
module pha_extract
    import pha_pkg::*;
#(
    parameter int DW        = 10,
    parameter int BASE_DLY  = 32,
    parameter int HOLDOFF   = 20,
    parameter int MAX_WIDTH = 255,
    parameter int OUT_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             smp_vld,
    input  logic [DW-1:0]    smp,
    input  logic             arm,
    input  logic [DW-1:0]    lld,
    output logic             ph_vld,
    output logic [DW-1:0]    ph,
    input  logic             ph_rdy,
    output logic             busy,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] rej_cnt
);

    localparam int WID_W  = $clog2(MAX_WIDTH + 1);
    localparam int PH_MAX = (1 << DW) - 1;

    state_t            state, nxt;
    logic              fill_done;
    logic [DW-1:0]     w0;
    logic [SUM_W-1:0]  sn, sb;
    logic [SUM_W-1:0]  base, peak;
    logic [WID_W-1:0]  wid;
    logic [15:0]       hold_cnt;
    logic [SUM_W-1:0]  diff, scaled;
    logic [DW-1:0]     height;
    logic              above, slot_free, emit_ok, emit_drop, reject;

    pha_window #(.DW(DW), .BASE_DLY(BASE_DLY)) u_window (
        .clk       (clk),
        .rstn      (rstn),
        .smp_vld   (smp_vld),
        .smp       (smp),
        .fill_done (fill_done),
        .w0        (w0),
        .sn        (sn),
        .sb        (sb)
    );

    assign above = (sn > base);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (!arm) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (smp_vld && fill_done && (w0 > lld)) nxt = TRACK;
                TRACK: if (smp_vld) begin
                    if (!above) nxt = (peak > base) ? EMIT : HOLD;
`ifdef PHA_PILEUP_REJECT_EN
                    else if (wid == WID_W'(MAX_WIDTH)) nxt = HOLD;
`endif
                end
                EMIT:  nxt = HOLD;
                HOLD:  if (smp_vld && hold_cnt <= 16'd1) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        slot_free = !ph_vld || ph_rdy;
        emit_ok   = arm && (state == EMIT) && slot_free;
        emit_drop = arm && (state == EMIT) && !slot_free;
`ifdef PHA_PILEUP_REJECT_EN
        reject    = arm && (state == TRACK) && smp_vld && above && (wid == WID_W'(MAX_WIDTH));
`else
        reject    = 1'b0;
`endif
        diff      = peak - base;
        scaled    = diff >> OUT_SHIFT;
        height    = (scaled > SUM_W'(PH_MAX)) ? '1 : scaled[DW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base     <= '0;
            peak     <= '0;
            wid      <= '0;
            hold_cnt <= '0;
        end else begin
            if (state == IDLE && nxt == TRACK) begin
                base <= sb;
                peak <= '0;
                wid  <= '0;
            end else if (state == TRACK && smp_vld && above) begin
                if (sn > peak) peak <= sn;
                if (wid != '1) wid <= wid + 1'b1;
            end
            if (state != HOLD && nxt == HOLD)
                hold_cnt <= 16'(HOLDOFF);
            else if (state == HOLD && smp_vld && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // A pending result survives disarm; only a handshake or a new emit changes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph_vld    <= 1'b0;
            ph        <= '0;
            pulse_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (emit_ok) begin
                ph_vld    <= 1'b1;
                ph        <= height;
                pulse_cnt <= sat_inc(pulse_cnt);
            end else if (ph_vld && ph_rdy) begin
                ph_vld <= 1'b0;
            end
            if (emit_drop) drop_cnt <= sat_inc(drop_cnt);
        end
    end

`ifdef PHA_PILEUP_REJECT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       rej_cnt <= '0;
        else if (reject) rej_cnt <= sat_inc(rej_cnt);
    end
`else
    assign rej_cnt = '0;
`endif

endmodule

// File: tb/tb_pha_extract.sv
// tb/tb_pha_extract.sv - directed scoreboard bench for pha_extract
module tb_pha_extract;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        smp_vld = 1'b0;
    logic [9:0]  smp = '0;
    logic        arm = 1'b0;
    logic [9:0]  lld = 10'd540;
    logic        ph_rdy = 1'b1;
    logic        ph_vld;
    logic [9:0]  ph;
    logic        busy;
    logic [15:0] pulse_cnt, drop_cnt, rej_cnt;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int exp_pulse = 0, exp_drop = 0, exp_rej = 0;

    pha_extract dut (
        .clk       (clk),
        .rstn      (rstn),
        .smp_vld   (smp_vld),
        .smp       (smp),
        .arm       (arm),
        .lld       (lld),
        .ph_vld    (ph_vld),
        .ph        (ph),
        .ph_rdy    (ph_rdy),
        .busy      (busy),
        .pulse_cnt (pulse_cnt),
        .drop_cnt  (drop_cnt),
        .rej_cnt   (rej_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] v);
        smp = v;
        smp_vld = 1'b1;
        @(posedge clk);
        #1;
        smp_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [9:0] v);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pulse_cnt"}, pulse_cnt, exp_pulse);
        check({tag, "_drop_cnt"},  drop_cnt,  exp_drop);
        check({tag, "_rej_cnt"},   rej_cnt,   exp_rej);
        check({tag, "_sb_empty"},  exp_q.size(), 0);
    endtask

    // Every handshake must match the oldest expected height.
    always @(negedge clk) begin
        if (rstn && ph_vld && ph_rdy) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_ph: observed %0d expected none", ph);
            end
            if (exp_q.size() != 0) begin
                int e;
                e = exp_q.pop_front();
                tests++;
                assert (ph === 10'(e)) else begin
                    fails++;
                    $error("FAIL ph_value: observed %0d expected %0d", ph, e);
                end
            end
        end
    end

    initial begin
        clocks(3);
        check("rst_ph_vld", ph_vld, 0);
        check("rst_ph", ph, 0);
        check("rst_busy", busy, 0);
        check_counts("rst");
        rstn = 1'b1;
        arm = 1'b1;
        clocks(2);

        // basic pulse
        run(100, 10'd512);
        exp_q.push_back(150);
        exp_pulse++;
        run(6, 10'd612);
        run(40, 10'd512);
        check("t1_busy", busy, 0);
        check_counts("t1");

        // saturated height
        run(60, 10'd0);
        lld = 10'd10;
        exp_q.push_back(1023);
        exp_pulse++;
        run(8, 10'd1023);
        run(40, 10'd0);
        lld = 10'd540;
        check_counts("t2");
        run(100, 10'd512);

        // full slot: second pulse dropped, first held
        ph_rdy = 1'b0;
        exp_q.push_back(150);
        exp_pulse++;
        run(6, 10'd612);
        run(100, 10'd512);
        exp_drop++;
        run(6, 10'd612);
        run(40, 10'd512);
        check("t3_ph_vld_held", ph_vld, 1);
        check("t3_ph_held", ph, 150);
        check("t3_drop_cnt", drop_cnt, exp_drop);
        check("t3_pulse_cnt", pulse_cnt, exp_pulse);
        ph_rdy = 1'b1;
        clocks(3);
        check("t3_ph_vld_clear", ph_vld, 0);
        check_counts("t3");

        // second pulse inside holdoff is ignored
        exp_q.push_back(150);
        exp_pulse++;
        run(6, 10'd612);
        run(18, 10'd512);
        run(6, 10'd612);
        run(60, 10'd512);
        check_counts("t4a");
        run(100, 10'd512);

        // second pulse after holdoff; its baseline still holds one pulse sample
        exp_q.push_back(150);
        exp_pulse++;
        run(6, 10'd612);
        run(38, 10'd512);
        exp_q.push_back(125);
        exp_pulse++;
        run(6, 10'd612);
        run(100, 10'd512);
        check_counts("t4b");

        // long pulse
`ifdef PHA_PILEUP_REJECT_EN
        exp_rej++;
`else
        exp_q.push_back(376);
        exp_pulse++;
`endif
        run(300, 10'd700);
        run(100, 10'd512);
        check_counts("t5");

        // reset in TRACK
        run(100, 10'd512);
        run(3, 10'd612);
        check("t6_busy_track", busy, 1);
        rstn = 1'b0;
        clocks(1);
        check("t6_busy_rst", busy, 0);
        check("t6_ph_vld_rst", ph_vld, 0);
        exp_pulse = 0;
        exp_drop = 0;
        exp_rej = 0;
        check_counts("t6_rst");
        rstn = 1'b1;
        run(40, 10'd700);
        check("t6_no_trig_40", busy, 0);
        run(1, 10'd700);
        check("t6_trig_41", busy, 1);
        run(100, 10'd512);
        check_counts("t6");

        // disarm in TRACK
        run(3, 10'd612);
        check("t7_busy_track", busy, 1);
        arm = 1'b0;
        clocks(1);
        check("t7_busy_disarm", busy, 0);
        run(3, 10'd612);
        run(40, 10'd512);
        check("t7_ph_vld", ph_vld, 0);
        arm = 1'b1;
        run(40, 10'd512);
        check("t7_busy_end", busy, 0);
        check_counts("t7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
